mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Memory/IO access sequencer between the LC-3 datapath (MAR/MDR) and the board's asynchronous SRAM plus memory-mapped switches and hex display. It replaces the control unit's fixed wait states with a four-phase Req/Ready handshake, so memory latency becomes a parameter rather than an FSM edit. The control unit raises Req with R_W. This block drives the SRAM strobes, counts wait cycles, and returns read data for MDR.

## Interface
- WAIT_CYCLES, 2, SRAM access cycles per operation; legal range 1–15
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  1  access request, level, four-phase
- R_W  in  1  1 = write, 0 = read; sampled at acceptance
- MAR  in  16  word address; sampled at acceptance
- MDR_In  in  16  write data; sampled at acceptance
- Ready  out  1  access complete; high until Req drops
- Data_Out  out  16  read data to MDR; valid while Ready is high after a read
- SRAM_Addr  out  20  {4'b0, latched MAR}
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low strobes
- SRAM_DQ_In  in  16  data from the SRAM pins
- SRAM_DQ_Out  out  16  latched write data
- SRAM_DQ_OE  out  1  tri-state enable for the top-level DQ pad
- Switches  in  16  asynchronous board switches
- Hex_Out  out  16  hex display register

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if Req=1 at a clock edge, latch R_W, MAR and MDR_In.
  - An SRAM target goes to ACCESS with wait counter = WAIT_CYCLES−1.
  - An MMIO target (MAR = 16'hFFFF, macro defined) goes directly to DONE.
- ACCESS:
  - SRAM_CE_N=0 throughout.
  - Read: SRAM_OE_N=0.
  - Write: SRAM_WE_N=0 and SRAM_DQ_OE=1.
  - The counter decrements each cycle. At the edge where counter=0:
    - A read latches SRAM_DQ_In into Data_Out.
    - The FSM moves to DONE.
- DONE:
  - Ready=1 and all strobes are deasserted.
  - For a write, SRAM_DQ_OE stays 1, giving one cycle of data hold after WE_N rises.
  - The FSM leaves for IDLE only at an edge with Req=0. Req held high keeps it in DONE indefinitely, and no new access starts.
- MMIO read: Data_Out ← synchronized Switches. MMIO write: Hex_Out ← latched MDR_In. Both take effect at the acceptance edge.
- Data_Out and Hex_Out hold their values until the next read or MMIO write updates them.
- R_W, MAR and MDR_In changing after acceptance have no effect.
- Reset (Reset_n=0, any state, asynchronous):
  - State → IDLE, Ready=0.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N = 1; SRAM_DQ_OE=0.
  - SRAM_Addr=0, SRAM_DQ_Out=0, Data_Out=0, Hex_Out=0, switch synchronizer=0.
  - An in-flight write is aborted. Its SRAM contents are undefined.
- All outputs are registered or decoded from registered state only. No output has a combinational path from Req.

## Timing
- Req first sampled high at edge E. SRAM access: Ready rises in the cycle after edge E+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after Req rises. With the default this is 3 cycles, matching the old nR1/nR2/R fetch.
- MMIO access: Ready rises in the cycle after E.
- Ready falls in the cycle after the first edge that samples Req=0.
- The earliest next acceptance is the following edge, so back-to-back SRAM accesses take WAIT_CYCLES+2 cycles minimum.
- Switches pass through a 2-flop synchronizer, so switch changes are visible to reads 2 cycles later.

## Configuration
- MEM_IO_MMIO_EN defined:
  - Address 16'hFFFF decodes to Switches (read) and Hex_Out (write).
  - The SRAM is not touched for that address.
- Undefined:
  - All addresses, including 16'hFFFF, go to SRAM.
  - Hex_Out is tied to 0, Switches are ignored, and the synchronizer is not built.

## Structure
- Shared package lc3_mem_pkg:
  - state enum mem_state_t {IDLE, ACCESS, DONE}
  - MMIO_ADDR = 16'hFFFF
  - SRAM_ADDR_W = 20
- One sub-module, mmio_regs:
  - switch synchronizer plus Hex_Out register with a write strobe
  - instantiated only under MEM_IO_MMIO_EN

## Test plan
- Reset mid-write, asserted during the first ACCESS cycle → next cycle all strobes are 1, SRAM_DQ_OE=0, Ready=0, Hex_Out=0, state is IDLE.
- SRAM read at MAR=16'h3000, SRAM model returns 16'h1234, WAIT_CYCLES=2 → SRAM_OE_N low for exactly 2 cycles, Ready rises 3 cycles after Req, Data_Out=16'h1234.
- SRAM write at MAR=16'h3001, data 16'hBEEF → SRAM_WE_N low 2 cycles, SRAM_DQ_Out=16'hBEEF, SRAM_DQ_OE high for 3 cycles, then a readback returns 16'hBEEF.
- Req held high for 10 cycles after Ready → Ready stays 1, strobes stay 1, no second access. Drop Req → Ready=0 next cycle.
- MMIO_EN defined:
  - Write 16'h00A5 to 16'hFFFF → Hex_Out=16'h00A5 with Ready 1 cycle after Req and no SRAM strobes.
  - Switches=16'h5A5A, then read → Data_Out=16'h5A5A.
- MMIO_EN undefined, write to 16'hFFFF → SRAM_WE_N pulses, SRAM_Addr=20'h0FFFF, Hex_Out stays 0.

Source files
------------

// File: rtl/mem_io_ctrl_pkg.sv
// lc3_mem_pkg: shared state type, MMIO address and SRAM address width for the LC-3 memory sequencer
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

    localparam logic [15:0] MMIO_ADDR   = 16'hFFFF;
    localparam int          SRAM_ADDR_W = 20;

    function automatic logic is_mmio(input logic [15:0] addr);
        return addr == MMIO_ADDR;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_mmio_regs.sv
// mmio_regs: two-flop switch synchronizer and hex display register (built only with MEM_IO_MMIO_EN)
module mmio_regs (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_switches,
    input  logic        i_we,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_sw_sync,
    output logic [15:0] o_hex
);

    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [15:0] r_hex;

    // Bring the asynchronous switches into the clock domain and hold the display value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_hex     <= '0;
        end else begin
            r_sw_meta <= i_switches;
            r_sw_sync <= r_sw_meta;
            if (i_we)
                r_hex <= i_wdata;
        end
    end

    assign o_sw_sync = r_sw_sync;
    assign o_hex     = r_hex;

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: Req/Ready sequencer between LC-3 MAR/MDR and async SRAM; MEM_IO_MMIO_EN adds switch/hex MMIO at 16'hFFFF
module mem_io_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Req,
    input  logic                   R_W,
    input  logic [15:0]            MAR,
    input  logic [15:0]            MDR_In,
    output logic                   Ready,
    output logic [15:0]            Data_Out,
    output logic [SRAM_ADDR_W-1:0] SRAM_Addr,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    input  logic [15:0]            SRAM_DQ_In,
    output logic [15:0]            SRAM_DQ_Out,
    output logic                   SRAM_DQ_OE,
    input  logic [15:0]            Switches,
    output logic [15:0]            Hex_Out
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_data;
    logic        r_ready;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_dq_oe;
    logic        w_mmio;
    logic [15:0] w_sw_sync;

`ifdef MEM_IO_MMIO_EN
    logic w_hex_we;

    assign w_mmio   = is_mmio(MAR);
    assign w_hex_we = (r_state == IDLE) && Req && R_W && w_mmio;

    mmio_regs u_mmio_regs (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_switches (Switches),
        .i_we       (w_hex_we),
        .i_wdata    (MDR_In),
        .o_sw_sync  (w_sw_sync),
        .o_hex      (Hex_Out)
    );
`else
    logic w_unused_sw;

    assign w_mmio      = 1'b0;
    assign w_sw_sync   = '0;
    assign Hex_Out     = '0;
    assign w_unused_sw = ^Switches;
`endif

    // Access sequencer: accept in IDLE, strobe SRAM for WAIT_CYCLES, hold Ready in DONE until Req drops
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (Req) begin
                    r_rw    <= R_W;
                    r_addr  <= MAR;
                    r_wdata <= MDR_In;
                    if (w_mmio) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        if (!R_W)
                            r_data <= w_sw_sync;
                    end else begin
                        r_state <= ACCESS;
                        r_cnt   <= CNT_INIT;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= R_W;
                        r_we_n  <= ~R_W;
                        r_dq_oe <= R_W;
                    end
                end
                ACCESS: if (r_cnt == 4'd0) begin
                    if (!r_rw)
                        r_data <= SRAM_DQ_In;
                    r_state <= DONE;
                    r_ready <= 1'b1;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                DONE: if (!Req) begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_dq_oe <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Ready       = r_ready;
    assign Data_Out    = r_data;
    assign SRAM_Addr   = {{(SRAM_ADDR_W - 16){1'b0}}, r_addr};
    assign SRAM_CE_N   = r_ce_n;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_DQ_Out = r_wdata;
    assign SRAM_DQ_OE  = r_dq_oe;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: table-driven bench for mem_io_ctrl with a behavioural SRAM; expectations follow MEM_IO_MMIO_EN
module tb_mem_io_ctrl;
    import lc3_mem_pkg::*;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_hex;
        int          lat;
        int          oe;
        int          we;
        int          dq;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        R_W = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR_In = '0;
    logic        Ready;
    logic [15:0] Data_Out;
    logic [19:0] SRAM_Addr;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    logic [15:0] SRAM_DQ_In;
    logic [15:0] SRAM_DQ_Out;
    logic        SRAM_DQ_OE;
    logic [15:0] Switches = 16'h5A5A;
    logic [15:0] Hex_Out;

    logic [15:0] mem [0:65535];
    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl [7];

    mem_io_ctrl #(.WAIT_CYCLES(2)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req         (Req),
        .R_W         (R_W),
        .MAR         (MAR),
        .MDR_In      (MDR_In),
        .Ready       (Ready),
        .Data_Out    (Data_Out),
        .SRAM_Addr   (SRAM_Addr),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_DQ_In  (SRAM_DQ_In),
        .SRAM_DQ_Out (SRAM_DQ_Out),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .Switches    (Switches),
        .Hex_Out     (Hex_Out)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: writes land on a clock edge while CE_N and WE_N are low
    always @(posedge Clk)
        if (!SRAM_CE_N && !SRAM_WE_N)
            mem[SRAM_Addr[15:0]] <= SRAM_DQ_Out;

    assign SRAM_DQ_In = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_Addr[15:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int hold, input string tag);
        int lat = 0;
        int oe = 0;
        int we = 0;
        int dq = 0;
        int ce = 0;
        logic [19:0] a = '0;
        logic [15:0] dqo = '0;
        @(negedge Clk);
        Req = 1'b1;
        R_W = v.rw;
        MAR = v.addr;
        MDR_In = v.wdata;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == 1) begin
                R_W = ~v.rw;
                MAR = ~v.addr;
                MDR_In = ~v.wdata;
            end
            if (!SRAM_CE_N) begin ce++; a = SRAM_Addr; end
            if (!SRAM_OE_N) oe++;
            if (!SRAM_WE_N) begin we++; dqo = SRAM_DQ_Out; end
            if (SRAM_DQ_OE) dq++;
        end while (!Ready && lat < 40);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " data_out"}, Data_Out, v.exp_rd);
        chk({tag, " hex_out"}, Hex_Out, v.exp_hex);
        chk({tag, " done_strobes"}, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (SRAM_DQ_OE) dq++;
            chk({tag, " hold_ready"}, Ready, 1'b1);
            chk({tag, " hold_strobes"}, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        end
        Req = 1'b0;
        @(negedge Clk);
        chk({tag, " ready_fall"}, Ready, 1'b0);
        chk({tag, " dq_oe_fall"}, SRAM_DQ_OE, 1'b0);
        if (hold == 0)
            chk({tag, " dq_oe_cycles"}, dq, v.dq);
        chk({tag, " oe_cycles"}, oe, v.oe);
        chk({tag, " we_cycles"}, we, v.we);
        chk({tag, " ce_cycles"}, ce, v.oe + v.we);
        if (v.oe + v.we > 0)
            chk({tag, " sram_addr"}, a, {4'h0, v.addr});
        if (v.we > 0)
            chk({tag, " dq_out"}, dqo, v.wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'h0000;
        mem[16'h3000] = 16'h1234;
        tbl[0] = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 16'h0000, 3, 2, 0, 0};
        tbl[1] = '{1'b1, 16'h3001, 16'hBEEF, 16'h1234, 16'h0000, 3, 0, 2, 3};
        tbl[2] = '{1'b0, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 3, 2, 0, 0};
        tbl[3] = '{1'b1, 16'h0000, 16'h0001, 16'hBEEF, 16'h0000, 3, 0, 2, 3};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 3, 2, 0, 0};
`ifdef MEM_IO_MMIO_EN
        tbl[5] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0001, 16'h00A5, 1, 0, 0, 0};
        tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h00A5, 1, 0, 0, 0};
`else
        tbl[5] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0001, 16'h0000, 3, 0, 2, 3};
        tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h0000, 3, 2, 0, 0};
`endif
        repeat (3) @(negedge Clk);
        chk("reset ready", Ready, 1'b0);
        chk("reset strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
        chk("reset addr", SRAM_Addr, 20'h0);
        chk("reset dq_out", SRAM_DQ_Out, 16'h0);
        chk("reset data_out", Data_Out, 16'h0);
        chk("reset hex_out", Hex_Out, 16'h0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 7; i++)
            run(tbl[i], 0, $sformatf("vec%0d", i));

        @(negedge Clk);
        Req = 1'b1;
        R_W = 1'b1;
        MAR = 16'h3005;
        MDR_In = 16'h1111;
        @(negedge Clk);
        chk("midwrite we_low", SRAM_WE_N, 1'b0);
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        chk("midwrite strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("midwrite dq_oe", SRAM_DQ_OE, 1'b0);
        chk("midwrite ready", Ready, 1'b0);
        chk("midwrite hex_out", Hex_Out, 16'h0);
        chk("midwrite data_out", Data_Out, 16'h0);
        chk("midwrite state", dut.r_state, IDLE);
        Req = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        run('{1'b0, 16'h3000, 16'h0000, 16'h1234, 16'h0000, 3, 2, 0, 0}, 0, "post_reset");
        run('{1'b0, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 3, 2, 0, 0}, 10, "req_held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
